regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for three result sources feeding one register-file write port.
// It also keeps a busy scoreboard that stalls issue on outstanding long-latency destinations.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter bit          LONG_RR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,

  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,

  input  logic            req2_valid,
  input  logic [4:0]      req2_rd,
  input  logic [XLEN-1:0] req2_data,
  output logic            req2_ready,

  input  logic            issue_valid,
  input  logic            issue_long,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            stall,

  output logic [31:0]     busy,
  output logic            wr_ena,
  output logic [4:0]      wr_reg,
  output logic [XLEN-1:0] wr_data,
  output logic            idle
);

  logic [31:0]     busy_q, busy_d;
  logic            last2_q;  // 1: req2 was the most recent long-path grant
  logic            hs0, hs1, hs2, hs_any;
  logic            pick1;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            issue_accept;

  // req0 always wins; a req1/req2 tie goes round-robin or to req1.
  always_comb begin
    req0_ready = rst_n;
    req1_ready = 1'b0;
    req2_ready = 1'b0;
    pick1      = !LONG_RR || last2_q;
    if (rst_n && !req0_valid) begin
      if (req1_valid && req2_valid) begin
        req1_ready = pick1;
        req2_ready = !pick1;
      end else begin
        req1_ready = req1_valid;
        req2_ready = req2_valid;
      end
    end
  end

  assign hs0    = req0_valid & req0_ready;
  assign hs1    = req1_valid & req1_ready;
  assign hs2    = req2_valid & req2_ready;
  assign hs_any = hs0 | hs1 | hs2;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    if (hs0) begin
      sel_rd   = req0_rd;
      sel_data = req0_data;
    end else if (hs1) begin
      sel_rd   = req1_rd;
      sel_data = req1_data;
    end else if (hs2) begin
      sel_rd   = req2_rd;
      sel_data = req2_data;
    end
  end

  assign stall = rst_n & issue_valid &
                 (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
  assign issue_accept = issue_valid & ~stall;

  // Clear before set so a same-cycle set on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (hs1) busy_d[req1_rd] = 1'b0;
    if (hs2) busy_d[req2_rd] = 1'b0;
    if (issue_accept && issue_long && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      last2_q <= 1'b1;
      wr_ena  <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      busy_q <= busy_d;
      wr_ena <= hs_any && (sel_rd != 5'd0);
      if (hs_any) begin
        wr_reg  <= sel_rd;
        wr_data <= sel_data;
      end
      if (hs1 || hs2) last2_q <= hs2;
    end
  end

  assign busy = busy_q;
  assign idle = (busy_q == 32'd0) && !wr_ena;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a behavioural arbiter/scoreboard model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid, req2_valid;
  logic [4:0]      req0_rd, req1_rd, req2_rd;
  logic [XLEN-1:0] req0_data, req1_data, req2_data;
  logic            req0_ready, req1_ready, req2_ready;
  logic            issue_valid, issue_long;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic            stall;
  logic [31:0]     busy;
  logic            wr_ena;
  logic [4:0]      wr_reg;
  logic [XLEN-1:0] wr_data;
  logic            idle;

  regfile_wb_arbiter #(.XLEN(XLEN), .LONG_RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_rd(req2_rd), .req2_data(req2_data), .req2_ready(req2_ready),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .stall(stall),
    .busy(busy), .wr_ena(wr_ena), .wr_reg(wr_reg), .wr_data(wr_data), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: which registers await a long write-back, who won the last long tie,
  // and the write the port should be showing.
  bit        model_on = 0;
  bit [31:0] busy_m;
  int        last_m;
  bit        exp_en;
  bit        exp_known;
  bit [4:0]  exp_rd;
  bit [31:0] exp_data;

  function automatic int winner();
    if (!rst_n) return -1;
    if (req0_valid) return 0;
    if (req1_valid && req2_valid) return (last_m == 1) ? 2 : 1;
    if (req1_valid) return 1;
    if (req2_valid) return 2;
    return -1;
  endfunction

  function automatic bit stall_m();
    return rst_n && issue_valid &&
           (busy_m[issue_rs1] || busy_m[issue_rs2] || busy_m[issue_rd]);
  endfunction

  always @(posedge clk) begin
    int       w;
    bit [4:0] rd;
    bit [31:0] d;
    bit       acc;
    if (!rst_n) begin
      busy_m    = '0;
      last_m    = 2;
      exp_en    = 0;
      exp_known = 1;
      exp_rd    = '0;
      exp_data  = '0;
      model_on  = 1;
    end else begin
      w   = winner();
      acc = issue_valid && !stall_m();
      exp_en = 0;
      if (w >= 0) begin
        rd = (w == 0) ? req0_rd : (w == 1) ? req1_rd : req2_rd;
        d  = (w == 0) ? req0_data : (w == 1) ? req1_data : req2_data;
        exp_en    = (rd != 0);
        exp_known = exp_en;
        exp_rd    = rd;
        exp_data  = d;
        if (w != 0) begin
          busy_m[rd] = 1'b0;
          last_m     = w;
        end
      end
      if (acc && issue_long && issue_rd != 0) busy_m[issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    int w;
    if (model_on) begin
      w = winner();
      check("req0_ready", req0_ready, rst_n);
      check("req1_ready", req1_ready, w == 1);
      check("req2_ready", req2_ready, w == 2);
      check("stall", stall, stall_m());
      check("busy", busy, busy_m);
      check("wr_ena", wr_ena, exp_en);
      check("idle", idle, (busy_m == 0) && !exp_en);
      if (exp_known) begin
        check("wr_reg", wr_reg, exp_rd);
        check("wr_data", wr_data, exp_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    req2_valid = 0; req2_rd = 0; req2_data = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    issue_valid = 1; issue_rs1 = 3;
    tick();
    at_neg();
    check("lit_rst_req0_ready", req0_ready, 0);
    check("lit_rst_stall", stall, 0);
    tick();
    rst_n = 1;
    clear_inputs();
    at_neg();
    check("lit_post_rst_idle", idle, 1);
    check("lit_post_rst_wr_ena", wr_ena, 0);
    check("lit_post_rst_busy", busy, 0);
    tick();

    // ALU write-back, one-cycle latency
    req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
    at_neg();
    check("lit_alu_ready", req0_ready, 1);
    tick();
    clear_inputs();
    at_neg();
    check("lit_alu_wr_ena", wr_ena, 1);
    check("lit_alu_wr_reg", wr_reg, 5);
    check("lit_alu_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    at_neg();
    check("lit_alu_wr_once", wr_ena, 0);
    check("lit_alu_hold", wr_data, 32'hDEADBEEF);
    tick();

    // All three contend: req0 first, then req1/req2 alternate starting with req1
    req1_valid = 1; req1_rd = 11; req1_data = 32'hB1;
    req2_valid = 1; req2_rd = 12; req2_data = 32'hC2;
    req0_valid = 1; req0_data = 32'hA0;
    for (int i = 0; i < 3; i++) begin
      req0_rd = 5'(10 + i);
      at_neg();
      check("lit_rr_req0_first", {req0_ready, req1_ready, req2_ready}, 3'b100);
      tick();
    end
    req0_valid = 0;
    at_neg();
    check("lit_rr_req1", {req1_ready, req2_ready}, 2'b10);
    tick();
    req1_rd = 13; req1_data = 32'hB3;
    at_neg();
    check("lit_rr_req2", {req1_ready, req2_ready}, 2'b01);
    check("lit_rr_wr11", wr_reg, 11);
    tick();
    req2_rd = 14; req2_data = 32'hC4;
    at_neg();
    check("lit_rr_req1_again", {req1_ready, req2_ready}, 2'b10);
    check("lit_rr_wr12", wr_reg, 12);
    tick();
    clear_inputs();
    at_neg();
    check("lit_rr_wr13", wr_data, 32'hB3);
    tick();
    tick();

    // RAW stall on a long destination until its write-back
    issue_valid = 1; issue_long = 1; issue_rd = 7;
    at_neg();
    check("lit_raw_issue_ok", stall, 0);
    tick();
    issue_long = 0; issue_rd = 8; issue_rs1 = 7;
    at_neg();
    check("lit_raw_stall", stall, 1);
    check("lit_raw_busy7", busy, 32'h80);
    tick();
    at_neg();
    check("lit_raw_stall_hold", stall, 1);
    tick();
    req2_valid = 1; req2_rd = 7; req2_data = 32'h77;
    at_neg();
    check("lit_raw_wb_grant", req2_ready, 1);
    check("lit_raw_stall_wb", stall, 1);
    tick();
    req2_valid = 0;
    at_neg();
    check("lit_raw_released", stall, 0);
    check("lit_raw_busy_clear", busy, 0);
    tick();
    clear_inputs();

    // Same-cycle clear and set of one index: set wins
    req1_valid = 1; req1_rd = 9; req1_data = 32'h99;
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    at_neg();
    check("lit_setclr_ready", req1_ready, 1);
    tick();
    clear_inputs();
    at_neg();
    check("lit_setclr_busy9", busy, 32'h200);
    tick();
    req2_valid = 1; req2_rd = 9; req2_data = 32'h909;
    tick();
    clear_inputs();
    issue_valid = 1; issue_long = 1; issue_rd = 3;
    tick();
    clear_inputs();

    // Write-back to x0 handshakes but never writes
    req1_valid = 1; req1_rd = 0; req1_data = 32'h1234;
    at_neg();
    check("lit_x0_ready", req1_ready, 1);
    tick();
    clear_inputs();
    at_neg();
    check("lit_x0_no_write", wr_ena, 0);
    check("lit_x0_busy", busy, 32'h8);
    tick();

    // Reset mid-operation
    req0_valid = 1; req0_rd = 4; req0_data = 32'h44;
    tick();
    clear_inputs();
    rst_n = 0;
    req0_valid = 1; req1_valid = 1; req2_valid = 1;
    issue_valid = 1; issue_rs1 = 3;
    at_neg();
    check("lit_mid_rst_pre_wr", wr_ena, 1);
    check("lit_mid_rst_ready", {req0_ready, req1_ready, req2_ready}, 3'b000);
    check("lit_mid_rst_stall", stall, 0);
    tick();
    rst_n = 1;
    clear_inputs();
    at_neg();
    check("lit_mid_rst_busy", busy, 0);
    check("lit_mid_rst_wr_ena", wr_ena, 0);
    check("lit_mid_rst_idle", idle, 1);
    check("lit_mid_rst_wr_reg", wr_reg, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
